state_sequencer: RTL and testbench

STATE_SEQUENCER -- requirements
Module: state_sequencer

---
 rtl/mips_cpu_pkg.sv | 31 +++
 rtl/state_sequencer_if.sv | 24 ++
 rtl/instr_classifier.sv | 40 ++++
 rtl/state_sequencer.sv | 138 +++++++++++++
 tb/tb_state_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the sequencer state encoding (EXEC=0010 is fixed because the branch
// unit decodes it) and the opcode/function constants used by the classifier.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    StFetch     = 4'b0000,
    StDecode    = 4'b0001,
    StExec      = 4'b0010,
    StMem       = 4'b0011,
    StWriteback = 4'b0100,
    StHalted    = 4'b0101
  } state_e;

  // Full opcodes
  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpRegimm  = 6'b000001;
  localparam logic [5:0] OpJal     = 6'b000011;

  // Opcode class prefixes, opcode[5:3]
  localparam logic [2:0] OpClassImm   = 3'b001;
  localparam logic [2:0] OpClassLoad  = 3'b100;
  localparam logic [2:0] OpClassStore = 3'b101;

  // SPECIAL function codes that do not write a GPR
  localparam logic [5:0] FnJr      = 6'b001000;
  localparam logic [3:0] FnMultDiv = 4'b0110;  // fn[5:2]: MULT/MULTU/DIV/DIVU
  localparam logic [5:0] FnMthi    = 6'b010001;
  localparam logic [5:0] FnMtlo    = 6'b010011;

endpackage

// File: rtl/state_sequencer_if.sv
// Memory handshake between the state sequencer and the memory system.
//   waitrequest : memory not ready, the current access is held
//   mem_read    : read strobe (instruction fetch or load)
//   mem_write   : write strobe (store)
// master = sequencer side, slave = memory side.
interface state_sequencer_if;

  logic waitrequest;
  logic mem_read;
  logic mem_write;

  modport master (
    input  waitrequest,
    output mem_read,
    output mem_write
  );

  modport slave (
    output waitrequest,
    input  mem_read,
    input  mem_write
  );

endinterface

// File: rtl/instr_classifier.sv
// Combinational instruction classifier.
//   opcode_i, fn_i, info_i : fields of the instruction register (info_i = rt)
//   is_load_o              : opcode 100xxx
//   is_store_o             : opcode 101xxx
//   writes_gpr_o           : instruction class writes a general-purpose register
module instr_classifier
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] fn_i,
  input  logic [4:0] info_i,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       writes_gpr_o
);

  logic special_writes;
  logic unused_info;

  // Only rt[4] (the link bit of REGIMM branches) matters here.
  assign unused_info = ^info_i[3:0];

  always_comb begin
    is_load_o      = (opcode_i[5:3] == OpClassLoad);
    is_store_o     = (opcode_i[5:3] == OpClassStore);
    special_writes = !((fn_i == FnJr) || (fn_i[5:2] == FnMultDiv) ||
                       (fn_i == FnMthi) || (fn_i == FnMtlo));
    writes_gpr_o = 1'b0;
    if (opcode_i == OpSpecial) begin
      writes_gpr_o = special_writes;
    end else if (opcode_i[5:3] == OpClassImm) begin
      writes_gpr_o = 1'b1;
    end else if (opcode_i == OpJal) begin
      writes_gpr_o = 1'b1;
    end else if (opcode_i == OpRegimm) begin
      writes_gpr_o = info_i[4];
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// Multi-cycle CPU state sequencer: FETCH, DECODE, EXEC, MEM, WRITEBACK, HALTED.
//   clk, reset_n        : clock, asynchronous active-low reset
//   mem                 : memory handshake (waitrequest in, mem_read/mem_write out)
//   opcode, fn, info    : instruction register fields
//   JumpIN              : branch/jump taken, sampled in EXEC
//   pc_is_zero          : PC equals 0, halts the CPU at the next fetch
//   state               : current state, also feeds the branch unit
//   ir_en, pc_en        : IR load / PC update strobes
//   pc_sel_target       : PC update loads the branch target (delay slot done)
//   reg_write           : GPR write strobe
//   active              : CPU running
//   retired             : count of completed instructions
module state_sequencer
  import mips_cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  state_sequencer_if.master   mem,
  input  logic [5:0]          opcode,
  input  logic [5:0]          fn,
  input  logic [4:0]          info,
  input  logic                JumpIN,
  input  logic                pc_is_zero,
  output logic [3:0]          state,
  output logic                ir_en,
  output logic                pc_en,
  output logic                pc_sel_target,
  output logic                reg_write,
  output logic                active,
  output logic [31:0]         retired
);

  state_e      state_q, state_d;
  logic        branch_pending_q, branch_pending_d;
  logic [31:0] retired_q, retired_d;

  logic is_load, is_store, writes_gpr;
  logic rd_c, wr_c, ir_c, pc_c, rw_c, retire_c;

  instr_classifier u_classifier (
    .opcode_i     (opcode),
    .fn_i         (fn),
    .info_i       (info),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .writes_gpr_o (writes_gpr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StFetch;
      branch_pending_q <= 1'b0;
      retired_q        <= 32'd0;
    end else begin
      state_q          <= state_d;
      branch_pending_q <= branch_pending_d;
      retired_q        <= retired_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    ir_c     = 1'b0;
    pc_c     = 1'b0;
    rw_c     = 1'b0;
    retire_c = 1'b0;
    case (state_q)
      StFetch: begin
        if (pc_is_zero) begin
          state_d = StHalted;
        end else begin
          rd_c = 1'b1;
          if (!mem.waitrequest) begin
            ir_c    = 1'b1;
            pc_c    = 1'b1;
            state_d = StDecode;
          end
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (is_load || is_store) begin
          state_d = StMem;
        end else if (writes_gpr) begin
          state_d = StWriteback;
        end else begin
          state_d  = StFetch;
          retire_c = 1'b1;
        end
      end
      StMem: begin
        rd_c = is_load;
        wr_c = !is_load;
        if (!mem.waitrequest) begin
          if (is_load) begin
            state_d = StWriteback;
          end else begin
            state_d  = StFetch;
            retire_c = 1'b1;
          end
        end
      end
      StWriteback: begin
        rw_c     = 1'b1;
        state_d  = StFetch;
        retire_c = 1'b1;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StFetch;
    endcase
  end

  // A taken branch waits for the delay-slot fetch's PC update, then redirects
  // the one after it.
  always_comb begin
    branch_pending_d = branch_pending_q;
    if (pc_c) begin
      branch_pending_d = 1'b0;
    end else if ((state_q == StExec) && JumpIN) begin
      branch_pending_d = 1'b1;
    end
    retired_d = retired_q + {31'd0, retire_c};
  end

  // Strobes are gated by reset_n so an aborted access drops at the reset edge.
  assign mem.mem_read  = reset_n & rd_c;
  assign mem.mem_write = reset_n & wr_c;
  assign ir_en         = reset_n & ir_c;
  assign pc_en         = reset_n & pc_c;
  assign pc_sel_target = reset_n & pc_c & branch_pending_q;
  assign reg_write     = reset_n & rw_c;
  assign active        = (state_q != StHalted);
  assign state         = state_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_state_sequencer.sv
module tb_state_sequencer;

  localparam logic [3:0] SFetch  = 4'b0000;
  localparam logic [3:0] SDecode = 4'b0001;
  localparam logic [3:0] SExec   = 4'b0010;
  localparam logic [3:0] SMem    = 4'b0011;
  localparam logic [3:0] SWb     = 4'b0100;
  localparam logic [3:0] SHalted = 4'b0101;

  // Strobe vector bits: {mem_read, mem_write, ir_en, pc_en, pc_sel_target, reg_write, active}
  localparam logic [6:0] RD  = 7'b1000000;
  localparam logic [6:0] WR  = 7'b0100000;
  localparam logic [6:0] IR  = 7'b0010000;
  localparam logic [6:0] PC  = 7'b0001000;
  localparam logic [6:0] SEL = 7'b0000100;
  localparam logic [6:0] RW  = 7'b0000010;
  localparam logic [6:0] ACT = 7'b0000001;

  typedef struct packed {
    logic [3:0]  st;
    logic [6:0]  sb;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  fn = '0;
  logic [4:0]  info = '0;
  logic        jump_in = 1'b0;
  logic        pc_is_zero = 1'b0;
  logic [3:0]  state;
  logic        ir_en, pc_en, pc_sel_target, reg_write, active;
  logic [31:0] retired;

  state_sequencer_if mem_bus ();

  state_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem           (mem_bus),
    .opcode        (opcode),
    .fn            (fn),
    .info          (info),
    .JumpIN        (jump_in),
    .pc_is_zero    (pc_is_zero),
    .state         (state),
    .ir_en         (ir_en),
    .pc_en         (pc_en),
    .pc_sel_target (pc_sel_target),
    .reg_write     (reg_write),
    .active        (active),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned mon_cyc  = 0;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] exp_ret;
  logic [3:0]  prev_st;
  logic [5:0]  nxt_op;
  logic [5:0]  nxt_fn;
  logic [4:0]  nxt_info;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Instruction fields take effect at the start of the next driven cycle.
  task automatic instr(input logic [5:0] op, input logic [5:0] f, input logic [4:0] inf);
    nxt_op   = op;
    nxt_fn   = f;
    nxt_info = inf;
  endtask

  task automatic push_exp(input logic [3:0] st, input logic [6:0] sb);
    exp_t e;
    if ((prev_st == SExec || prev_st == SMem || prev_st == SWb) && st == SFetch) begin
      exp_ret = exp_ret + 32'd1;
    end
    prev_st = st;
    e.st  = st;
    e.sb  = sb;
    e.ret = exp_ret;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic w, input logic j, input logic pz,
                     input logic [3:0] st, input logic [6:0] sb);
    @(posedge clk);
    #1;
    reset_n             = 1'b1;
    mem_bus.waitrequest = w;
    jump_in             = j;
    pc_is_zero          = pz;
    opcode              = nxt_op;
    fn                  = nxt_fn;
    info                = nxt_info;
    push_exp(st, sb);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n             = 1'b0;
    mem_bus.waitrequest = 1'b1;
    jump_in             = 1'b0;
    pc_is_zero          = 1'b0;
    exp_ret             = 32'd0;
    prev_st             = SFetch;
    push_exp(SFetch, ACT);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_cyc++;
      check($sformatf("state c%0d", mon_cyc), {28'd0, state}, {28'd0, mon_e.st});
      check($sformatf("strobes c%0d", mon_cyc),
            {25'd0, mem_bus.mem_read, mem_bus.mem_write, ir_en, pc_en, pc_sel_target,
             reg_write, active},
            {25'd0, mon_e.sb});
      check($sformatf("retired c%0d", mon_cyc), retired, mon_e.ret);
    end
  end

  initial begin
    mem_bus.waitrequest = 1'b0;
    exp_ret  = 32'd0;
    prev_st  = SFetch;
    nxt_op   = '0;
    nxt_fn   = '0;
    nxt_info = '0;

    do_reset();

    // ADDU, no waits
    instr(6'b000000, 6'b100001, 5'd0);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);
    cyc(0, 0, 0, SWb,     RW | ACT);

    // LW with one fetch stall and three MEM wait cycles
    instr(6'b100011, 6'd0, 5'd0);
    cyc(1, 0, 0, SFetch,  RD | ACT);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, SMem, RD | ACT);
    cyc(0, 0, 0, SMem,    RD | ACT);
    cyc(0, 0, 0, SWb,     RW | ACT);

    // BEQ taken, then ADDU in the delay slot
    instr(6'b000100, 6'd0, 5'd0);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 1, 0, SExec,   ACT);
    instr(6'b000000, 6'b100001, 5'd0);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | SEL | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);
    cyc(0, 0, 0, SWb,     RW | ACT);

    // BGEZAL links (fetch here must not select the target any more)
    instr(6'b000001, 6'd0, 5'b10001);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);
    cyc(0, 0, 0, SWb,     RW | ACT);

    // BGEZ does not link
    instr(6'b000001, 6'd0, 5'b00001);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);

    // SW, no wait
    instr(6'b101011, 6'd0, 5'd0);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);
    cyc(0, 0, 0, SMem,    WR | ACT);

    // SW stalled in MEM, aborted by an asynchronous reset pulse
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);
    cyc(1, 0, 0, SMem,    WR | ACT);
    cyc(1, 0, 0, SMem,    WR | ACT);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_mem_write", {31'd0, mem_bus.mem_write}, 32'd0);
    check("async_state", {28'd0, state}, {28'd0, SFetch});
    check("async_retired", retired, 32'd0);
    check("async_active", {31'd0, active}, 32'd1);
    do_reset();

    // JR, delay slot ADDU, then PC=0 halts the CPU
    instr(6'b000000, 6'b001000, 5'd0);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 1, 0, SExec,   ACT);
    instr(6'b000000, 6'b100001, 5'd0);
    cyc(0, 0, 0, SFetch,  RD | IR | PC | SEL | ACT);
    cyc(0, 0, 0, SDecode, ACT);
    cyc(0, 0, 0, SExec,   ACT);
    cyc(0, 0, 0, SWb,     RW | ACT);
    cyc(0, 0, 1, SFetch,  ACT);
    cyc(0, 0, 1, SHalted, 7'b0000000);
    cyc(1, 0, 0, SHalted, 7'b0000000);
    cyc(0, 1, 1, SHalted, 7'b0000000);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
